// File: rtl/display_scan.sv
// Time-multiplexed scanner for a common-anode 7-segment display: one digit per
// slot, guard time between slots, leading-zero blanking, frame-synchronous updates.
module display_scan #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            seg_data,
  output logic                  seg_en,
  output logic                  frame_start
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*DIGITS-1:0]    disp_q, disp_d;
  logic [4*DIGITS-1:0]    shadow_q, shadow_d;
  logic                   pending_q, pending_d;
  logic [DIGITS-1:0]      an_q, an_d;
  logic [3:0]             seg_data_q, seg_data_d;
  logic                   seg_en_q, seg_en_d;
  logic                   frame_start_q, frame_start_d;
  logic                   tick, commit;

  // Digit i is dark when it and every more-significant nibble are zero.
  function automatic logic is_blanked(input logic [4*DIGITS-1:0] d,
                                      input logic [IW-1:0]       i,
                                      input logic                blz);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(i) && d[4*j +: 4] != 4'h0) all_zero = 1'b0;
    end
    return blz && (i != '0) && all_zero;
  endfunction

  always_comb begin
    tick          = (cnt_q == CW'(DIV - 1));
    commit        = tick && (idx_q == IW'(DIGITS - 1));
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    idx_d         = idx_q;
    if (tick) idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    shadow_d      = load ? value : shadow_q;
    pending_d     = load ? 1'b1 : pending_q;
    disp_d        = disp_q;
    if (commit) begin
      if (load) begin
        disp_d    = value;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end
    frame_start_d = commit;

    // Outputs are computed from the next state so they line up with cnt/idx/disp.
    an_d          = '1;
    seg_data_d    = 4'h0;
    seg_en_d      = 1'b0;
    if (int'(idx_d) < DIGITS) begin
      seg_data_d = disp_d[4*idx_d +: 4];
      if (cnt_d >= CW'(GUARD)) begin
        an_d[idx_d] = 1'b0;
        seg_en_d    = !is_blanked(disp_d, idx_d, blank_lz);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      disp_q        <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      an_q          <= '1;
      seg_data_q    <= 4'h0;
      seg_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      disp_q        <= disp_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      an_q          <= an_d;
      seg_data_q    <= seg_data_d;
      seg_en_q      <= seg_en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg_data    = seg_data_q;
  assign seg_en      = seg_en_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIGITS=4, DIV=8, GUARD=2.
module tb_display_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  an;
  logic [3:0]  seg_data;
  logic        seg_en;
  logic        frame_start;

  int total = 0;
  int bad   = 0;
  int cyc;
  logic [15:0] exp_disp;
  logic        blz_eff;

  display_scan #(.DIGITS(4), .DIV(8), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank_lz(blank_lz),
    .an(an), .seg_data(seg_data), .seg_en(seg_en), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Inputs set now are sampled at the next edge; blank_lz seen then is what the outputs use.
  task automatic adv();
    blz_eff = blank_lz;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg_en", {31'd0, seg_en}, 32'd0);
    chk("rst_seg_data", {28'd0, seg_data}, 32'd0);
    chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
  endtask

  task automatic check_cycle();
    int slot, cnt;
    logic [3:0] e_an, e_dig;
    logic e_en, blk;
    logic [15:0] hi;
    cnt   = cyc % 8;
    slot  = (cyc / 8) % 4;
    e_an  = (cnt < 2) ? 4'hF : ~(4'b0001 << slot);
    e_dig = exp_disp[4*slot +: 4];
    hi    = exp_disp >> (4*slot);
    blk   = blz_eff && (slot > 0) && (hi == 16'h0);
    e_en  = (cnt >= 2) && !blk;
    chk("an", {28'd0, an}, {28'd0, e_an});
    chk("seg_data", {28'd0, seg_data}, {28'd0, e_dig});
    chk("seg_en", {31'd0, seg_en}, {31'd0, e_en});
    chk("frame_start", {31'd0, frame_start}, {31'd0, (cyc > 0) && (cyc % 32 == 0)});
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value = 16'h0; blank_lz = 1'b0; blz_eff = 1'b0;
    cyc = 0; exp_disp = 16'h0;
    repeat (3) begin
      adv();
      check_reset_vals();
    end
    rst_n = 1'b1;

    for (cyc = 0; cyc <= 213; cyc++) begin
      case (cyc)
        32:  exp_disp = 16'hABCD;
        64:  exp_disp = 16'h5A5A;
        96:  exp_disp = 16'h0050;
        128: exp_disp = 16'h0000;
        192: exp_disp = 16'h0007;
        default: ;
      endcase
      check_cycle();
      if (cyc == 213) break;
      load = 1'b0;
      case (cyc)
        10:  begin load = 1'b1; value = 16'h1234; end
        20:  begin load = 1'b1; value = 16'hABCD; end
        63:  begin load = 1'b1; value = 16'h5A5A; end
        70:  begin load = 1'b1; value = 16'h0050; end
        90:  blank_lz = 1'b1;
        100: begin load = 1'b1; value = 16'h0000; end
        159: blank_lz = 1'b0;
        170: begin load = 1'b1; value = 16'h0007; end
        195: begin load = 1'b1; value = 16'h9999; end
        default: ;
      endcase
      adv();
    end

    // Reset lands at idx=2, cnt=5 with 9999 still pending.
    load  = 1'b0;
    rst_n = 1'b0;
    adv();
    check_reset_vals();
    rst_n = 1'b1;
    exp_disp = 16'h0;
    for (cyc = 0; cyc <= 40; cyc++) begin
      check_cycle();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
